// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults (DBIT, SB_TICK, BAUD_DIV) and the 2-bit transmitter FSM encoding
package uart_pkg;
  localparam int DBIT_DEF = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int BAUD_DIV_DEF = 163;
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: sync FIFO, registered count; in clk, reset(async low), push, pop, din; out dout, empty, full
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with FIFO; in clk, reset(async low), tx_wr, tx_din[7:0]; out tx_full, tx_busy, tx_done_tick, tx
module uart_tx import uart_pkg::*; #(
  parameter int DBIT = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_wr,
  input  logic [7:0] tx_din,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(DBIT);
  localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  state_t state, state_n;
  logic [BW-1:0] bc;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [7:0] b, b_n, dout;
  logic tx_r, tx_n, pop, empty, s_tick;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_wr),
    .pop(pop),
    .din(tx_din),
    .dout(dout),
    .empty(empty),
    .full(tx_full)
  );
  assign s_tick = bc == BW'(BAUD_DIV - 1);
  assign tx_busy = state != IDLE || !empty;
  assign tx = tx_r;
  always_ff @(posedge clk or negedge reset)
    if (!reset) bc <= '0;
    else bc <= (state == IDLE || s_tick) ? '0 : bc + BW'(1);
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    tx_n = tx_r;
    pop = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          b_n = dout;
          s_n = '0;
          state_n = START;
          tx_n = 1'b0;
        end
      end
      START:
        if (s_tick) begin
          if (s == SW'(15)) begin
            state_n = DATA;
            s_n = '0;
            n_n = '0;
            tx_n = b[0];
          end else s_n = s + SW'(1);
        end
      DATA:
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == NW'(DBIT - 1)) begin
              state_n = STOP;
              tx_n = 1'b1;
            end else begin
              n_n = n + NW'(1);
              tx_n = b[1];
            end
          end else s_n = s + SW'(1);
        end
      STOP:
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            state_n = IDLE;
            tx_done_tick = 1'b1;
          end else s_n = s + SW'(1);
        end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      tx_r <= 1'b1;
    end else begin
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      tx_r <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at BAUD_DIV=4 (bit = 64 clocks, frame = 640 clocks)
module tb_uart_tx;
  logic clk = 0, reset = 1, tx_wr = 0;
  logic [7:0] tx_din = 0;
  logic tx_full, tx_busy, tx_done_tick, tx;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] exp_q[$];
  uart_tx #(.BAUD_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .tx_wr(tx_wr),
    .tx_din(tx_din),
    .tx_full(tx_full),
    .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx(tx)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_n(input int n, output bit ok);
    ok = 1;
    for (int i = 0; i < n && ok; i++) begin
      @(negedge clk);
      ok = reset;
    end
  endtask
  task automatic write_byte(input logic [7:0] v, input bit keep);
    @(negedge clk);
    tx_wr = 1;
    tx_din = v;
    if (keep) exp_q.push_back(v);
    @(negedge clk);
    tx_wr = 0;
  endtask
  task automatic wait_idle(input int lim, input string name);
    int i = 0;
    while (tx_busy && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(name, tx_busy, 0);
  endtask
  function automatic logic exp_tx(input int k, input logic [7:0] v);
    if (k < 1 || k > 576) return 1'b1;
    if (k <= 64) return 1'b0;
    return v[(k - 65) / 64];
  endfunction
  initial begin : monitor
    logic [7:0] d;
    bit ok;
    forever begin
      do @(negedge clk); while (!(reset && !tx));
      wait_n(32, ok);
      if (ok) chk("rx_start_bit", tx, 0);
      for (int i = 0; i < 8 && ok; i++) begin
        wait_n(64, ok);
        d[i] = tx;
      end
      if (ok) wait_n(64, ok);
      if (ok) begin
        chk("rx_stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected_frame: got byte %0h expected no frame", d);
        end else chk("rx_byte", d, exp_q.pop_front());
      end
    end
  end
  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1);
  end
  initial begin
    int rise, gap, d0, d1, lows;
    logic p;
    #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_full", tx_full, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done_tick, 0);
      tx_wr = i[0];
      tx_din = 8'h5a;
    end
    @(negedge clk);
    tx_wr = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_writes_dropped_busy", tx_busy, 0);
    chk("rst_idle_tx", tx, 1);
    write_byte(8'ha5, 1);
    for (int k = 1; k <= 645; k++) begin
      @(negedge clk);
      chk($sformatf("a5_tx@%0d", k), tx, exp_tx(k, 8'ha5));
      chk($sformatf("a5_done@%0d", k), tx_done_tick, k == 640);
      chk($sformatf("a5_busy@%0d", k), tx_busy, k <= 640);
    end
    chk("a5_drained", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_full_before_wr%0d", i), tx_full, i == 5);
      tx_wr = 1;
      tx_din = 8'(8'h11 + i);
      if (i < 5) exp_q.push_back(8'(8'h11 + i));
    end
    @(negedge clk);
    tx_wr = 0;
    wait_idle(4000, "ovf_idle_timeout");
    chk("ovf_drained", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    @(negedge clk);
    tx_wr = 1;
    tx_din = 8'h00;
    exp_q.push_back(8'h00);
    @(negedge clk);
    tx_din = 8'hff;
    exp_q.push_back(8'hff);
    @(negedge clk);
    tx_wr = 0;
    rise = -1;
    gap = -1;
    d0 = -1;
    d1 = -1;
    p = 1;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (tx && !p && rise < 0) rise = cyc;
      if (!tx && p && rise >= 0 && gap < 0) gap = cyc - rise;
      if (tx_done_tick) begin
        if (d0 < 0) d0 = cyc;
        else d1 = cyc;
      end
      p = tx;
    end
    chk("b2b_gap", gap, 65);
    chk("b2b_done_spacing", d1 - d0, 641);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_idle", tx_busy, 0);
    write_byte(8'h3c, 1);
    write_byte(8'h01, 0);
    write_byte(8'h02, 0);
    repeat (285) @(negedge clk);
    reset = 0;
    exp_q.delete();
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_full", tx_full, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    lows = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("abort_low_cycles_after_release", lows, 0);
    chk("abort_busy_after_release", tx_busy, 0);
    write_byte(8'h00, 1);
    write_byte(8'h55, 1);
    write_byte(8'haa, 1);
    write_byte(8'hff, 1);
    wait_idle(3500, "loop_idle_timeout");
    chk("loop_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
